bp_be_stride_prefetcher: RTL and testbench

- Multi-entry, parametrised reference-prediction-table (RPT) stride detector with an integrated prefetch-issue engine.
- Trains on resolved memory-op (pc, effective address) pairs from the BE pipeline and tracks a per-PC stride with a saturating confidence counter.
- On confident stride confirmation, issues degree_p prefetch addresses over a valid/ready interface towards the D$ prefetch port.
- Prefetches never cross a 4 KiB page.

---
 rtl/bp_be_stride_prefetcher.sv | 208 ++++++++++++++++++++
 tb/tb_bp_be_stride_prefetcher.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/bp_be_stride_prefetcher.sv
// Stride prefetcher: a direct-mapped reference-prediction table learns a
// per-PC stride from resolved (pc, addr) pairs, and an issue engine emits
// degree_p prefetch addresses within the trigger's 4 KiB page.
//
// Ports:
//   clk_i          clock
//   reset_i        asynchronous active-high reset
//   flush_i        invalidate the table and abort any issue in progress
//   train_v_i      training beat valid
//   train_pc_i     PC of the memory op
//   train_addr_i   effective address of the memory op
//   train_store_i  memory op is a store
//   pf_v_o         prefetch request valid (registered)
//   pf_addr_o      prefetch address, 0 while pf_v_o is low (registered)
//   pf_ready_i     consumer accepts; handshake is pf_v_o & pf_ready_i
//   pf_drop_o      one-cycle pulse: a trigger was lost because the engine was busy
module bp_be_stride_prefetcher #(
  parameter int unsigned vaddr_width_p  = 39,
  parameter int unsigned stride_width_p = 12,
  parameter int unsigned rpt_entries_p  = 16,
  parameter int unsigned tag_width_p    = 10,
  parameter int unsigned conf_width_p   = 2,
  parameter int unsigned conf_thresh_p  = 2,
  parameter int unsigned degree_p       = 2,
  parameter int unsigned train_stores_p = 1
) (
  input  logic                     clk_i,
  input  logic                     reset_i,
  input  logic                     flush_i,
  input  logic                     train_v_i,
  input  logic [vaddr_width_p-1:0] train_pc_i,
  input  logic [vaddr_width_p-1:0] train_addr_i,
  input  logic                     train_store_i,
  output logic                     pf_v_o,
  output logic [vaddr_width_p-1:0] pf_addr_o,
  input  logic                     pf_ready_i,
  output logic                     pf_drop_o
);

  localparam int unsigned va_w     = vaddr_width_p;
  localparam int unsigned st_w     = stride_width_p;
  localparam int unsigned idx_w    = $clog2(rpt_entries_p);
  localparam int unsigned tag_lsb  = idx_w + 2;
  localparam int unsigned conf_w   = conf_width_p;
  localparam int unsigned k_w      = $clog2(degree_p + 1);
  localparam int unsigned page_lsb = 12;

  localparam logic [conf_w-1:0] conf_max    = '1;
  localparam logic [conf_w-1:0] conf_thresh = conf_w'(conf_thresh_p);
  localparam logic [k_w-1:0]    k_last      = k_w'(degree_p);
  localparam logic              stores_ok   = (train_stores_p != 0);

  localparam logic [0:0] e_idle  = 1'b0;
  localparam logic [0:0] e_issue = 1'b1;

  // Reference prediction table
  logic [rpt_entries_p-1:0] tbl_v;
  logic [tag_width_p-1:0]   tbl_tag  [rpt_entries_p];
  logic [va_w-1:0]          tbl_last [rpt_entries_p];
  logic [st_w-1:0]          tbl_str  [rpt_entries_p];
  logic [conf_w-1:0]        tbl_conf [rpt_entries_p];

  logic [idx_w-1:0]       idx;
  logic [tag_width_p-1:0] tag;
  logic                   accept;
  logic                   unused_pc;

  assign idx       = train_pc_i[tag_lsb-1:2];
  assign tag       = train_pc_i[tag_lsb +: tag_width_p];
  assign accept    = train_v_i & ~flush_i & (stores_ok | ~train_store_i);
  assign unused_pc = ^{train_pc_i[1:0], train_pc_i[va_w-1:tag_lsb+tag_width_p]};

  // Lookup and training update for the indexed entry
  logic [st_w-1:0]   e_str;
  logic [conf_w-1:0] e_conf;
  logic [conf_w-1:0] conf_inc;
  logic [va_w-1:0]   delta;
  logic [va_w-1:0]   e_str_sext;
  logic              hit, fits, match, trigger;
  logic [st_w-1:0]   new_str;
  logic [conf_w-1:0] new_conf;

  always_comb begin
    e_str      = tbl_str[idx];
    e_conf     = tbl_conf[idx];
    hit        = tbl_v[idx] && (tbl_tag[idx] == tag);
    delta      = train_addr_i - tbl_last[idx];
    e_str_sext = {{(va_w-st_w){e_str[st_w-1]}}, e_str};
    // delta fits the signed stride field when its upper bits are a pure sign extension
    fits       = (&delta[va_w-1:st_w-1]) | ~(|delta[va_w-1:st_w-1]);
    match      = (delta == e_str_sext) && (delta != '0);
    conf_inc   = (e_conf == conf_max) ? e_conf : e_conf + conf_w'(1);
    new_str    = '0;
    new_conf   = '0;
    if (hit) begin
      if (match) begin
        new_str  = e_str;
        new_conf = conf_inc;
      end else if ((delta != '0) && fits) begin
        new_str  = delta[st_w-1:0];
      end
    end
    trigger = accept & hit & match & (conf_inc >= conf_thresh);
  end

  // Valid bits: cleared by flush, set on any accepted beat (miss allocates)
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      tbl_v <= '0;
    end else if (flush_i) begin
      tbl_v <= '0;
    end else if (accept) begin
      tbl_v[idx] <= 1'b1;
    end
  end

  // Entry payload; only meaningful while the valid bit is set
  always_ff @(posedge clk_i) begin
    if (accept) begin
      tbl_tag[idx]  <= tag;
      tbl_last[idx] <= train_addr_i;
      tbl_str[idx]  <= new_str;
      tbl_conf[idx] <= new_conf;
    end
  end

  // Issue engine state
  logic [0:0]      state_q, state_n;
  logic [va_w-1:0] base_q, base_n;
  logic [st_w-1:0] str_q, str_n;
  logic [k_w-1:0]  k_q, k_n;
  logic            pf_v_q, pf_v_n;
  logic [va_w-1:0] pf_addr_q, pf_addr_n;
  logic            drop_q, drop_n;
  logic            hs, trig_acc;
  logic [va_w-1:0] cand_n;

  assign hs = pf_v_q & pf_ready_i;

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q   <= e_idle;
      base_q    <= '0;
      str_q     <= '0;
      k_q       <= '0;
      pf_v_q    <= 1'b0;
      pf_addr_q <= '0;
      drop_q    <= 1'b0;
    end else begin
      state_q   <= state_n;
      base_q    <= base_n;
      str_q     <= str_n;
      k_q       <= k_n;
      pf_v_q    <= pf_v_n;
      pf_addr_q <= pf_addr_n;
      drop_q    <= drop_n;
    end
  end

  // Next state; the outputs are precomputed for the next cycle so that
  // pf_v_o/pf_addr_o come straight from flops
  always_comb begin
    state_n  = state_q;
    base_n   = base_q;
    str_n    = str_q;
    k_n      = k_q;
    drop_n   = 1'b0;
    trig_acc = trigger && ((state_q == e_idle) || (hs && (k_q == k_last)));

    case (state_q)
      e_idle: ;
      e_issue: begin
        // pf_v_q low while issuing means the candidate left the page
        if (!pf_v_q) begin
          state_n = e_idle;
        end else if (hs) begin
          if (k_q == k_last) state_n = e_idle;
          else               k_n     = k_q + k_w'(1);
        end
      end
      default: state_n = e_idle;
    endcase

    if (trig_acc) begin
      state_n = e_issue;
      base_n  = train_addr_i;
      str_n   = e_str;
      k_n     = k_w'(1);
    end else if (trigger) begin
      drop_n  = 1'b1;
    end

    if (flush_i) begin
      state_n = e_idle;
    end

    cand_n    = base_n + ({{(va_w-st_w){str_n[st_w-1]}}, str_n}
                          * {{(va_w-k_w){1'b0}}, k_n});
    pf_v_n    = (state_n == e_issue)
                && (cand_n[va_w-1:page_lsb] == base_n[va_w-1:page_lsb]);
    pf_addr_n = pf_v_n ? cand_n : '0;
  end

  assign pf_v_o    = pf_v_q;
  assign pf_addr_o = pf_addr_q;
  assign pf_drop_o = drop_q;

endmodule

// File: tb/tb_bp_be_stride_prefetcher.sv
// Directed bench for bp_be_stride_prefetcher: training, issue, backpressure,
// drop, page crossing, aliasing, flush and asynchronous reset.
module tb_bp_be_stride_prefetcher;

  localparam int unsigned VA = 39;

  logic          clk_i;
  logic          reset_i;
  logic          flush_i;
  logic          train_v_i;
  logic [VA-1:0] train_pc_i;
  logic [VA-1:0] train_addr_i;
  logic          train_store_i;
  logic          pf_v_o;
  logic [VA-1:0] pf_addr_o;
  logic          pf_ready_i;
  logic          pf_drop_o;

  int n_asserts;
  int n_fail;

  bp_be_stride_prefetcher dut (
    .clk_i         (clk_i),
    .reset_i       (reset_i),
    .flush_i       (flush_i),
    .train_v_i     (train_v_i),
    .train_pc_i    (train_pc_i),
    .train_addr_i  (train_addr_i),
    .train_store_i (train_store_i),
    .pf_v_o        (pf_v_o),
    .pf_addr_o     (pf_addr_o),
    .pf_ready_i    (pf_ready_i),
    .pf_drop_o     (pf_drop_o)
  );

  initial begin
    clk_i = 1'b0;
    forever #5 clk_i = ~clk_i;
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_asserts++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic beat(input logic [63:0] pc, input logic [63:0] addr);
    train_v_i    = 1'b1;
    train_pc_i   = VA'(pc);
    train_addr_i = VA'(addr);
    tick();
    train_v_i    = 1'b0;
  endtask

  task automatic expect_pf(input string tag, input logic v, input logic [63:0] addr);
    check_eq({tag, "_v"}, 64'(pf_v_o), 64'(v));
    check_eq({tag, "_addr"}, 64'(pf_addr_o), addr);
  endtask

  initial begin
    n_asserts     = 0;
    n_fail        = 0;
    reset_i       = 1'b1;
    flush_i       = 1'b0;
    train_v_i     = 1'b0;
    train_pc_i    = '0;
    train_addr_i  = '0;
    train_store_i = 1'b0;
    pf_ready_i    = 1'b1;
    #12;
    expect_pf("rst", 1'b0, 64'h0);
    check_eq("rst_drop", 64'(pf_drop_o), 64'h0);
    reset_i = 1'b0;
    tick();

    // Positive stride 0x40
    beat(64'h8000_0100, 64'h1000); expect_pf("p_b1", 1'b0, 64'h0);
    beat(64'h8000_0100, 64'h1040); expect_pf("p_b2", 1'b0, 64'h0);
    beat(64'h8000_0100, 64'h1080); expect_pf("p_b3", 1'b0, 64'h0);
    beat(64'h8000_0100, 64'h10C0); expect_pf("p_pf1", 1'b1, 64'h1100);
    tick();                        expect_pf("p_pf2", 1'b1, 64'h1140);
    tick();                        expect_pf("p_done", 1'b0, 64'h0);

    // Negative stride -8, trained by stores
    train_store_i = 1'b1;
    beat(64'h8000_0204, 64'h5100);
    beat(64'h8000_0204, 64'h50F8);
    beat(64'h8000_0204, 64'h50F0); expect_pf("n_b3", 1'b0, 64'h0);
    beat(64'h8000_0204, 64'h50E8); expect_pf("n_pf1", 1'b1, 64'h50E0);
    train_store_i = 1'b0;
    tick();                        expect_pf("n_pf2", 1'b1, 64'h50D8);
    tick();                        expect_pf("n_done", 1'b0, 64'h0);

    // Backpressure plus a competing trigger from another PC
    beat(64'h8000_010C, 64'h3000);
    beat(64'h8000_010C, 64'h3010);
    beat(64'h8000_010C, 64'h3020);
    beat(64'h8000_0108, 64'h1000);
    beat(64'h8000_0108, 64'h1040);
    beat(64'h8000_0108, 64'h1080);
    pf_ready_i = 1'b0;
    beat(64'h8000_0108, 64'h10C0); expect_pf("bp_c1", 1'b1, 64'h1100);
    check_eq("bp_c1_drop", 64'(pf_drop_o), 64'h0);
    beat(64'h8000_010C, 64'h3030); expect_pf("bp_c2", 1'b1, 64'h1100);
    check_eq("bp_drop_pulse", 64'(pf_drop_o), 64'h1);
    tick();                        expect_pf("bp_c3", 1'b1, 64'h1100);
    check_eq("bp_drop_end", 64'(pf_drop_o), 64'h0);
    pf_ready_i = 1'b1;
    tick();                        expect_pf("bp_pf2", 1'b1, 64'h1140);
    tick();                        expect_pf("bp_done", 1'b0, 64'h0);

    // Page crossing: first candidate 0x2000 leaves page 0x1000
    beat(64'h8000_0118, 64'h1F00);
    beat(64'h8000_0118, 64'h1F40);
    beat(64'h8000_0118, 64'h1F80);
    beat(64'h8000_0118, 64'h1FC0); expect_pf("pg_trig", 1'b0, 64'h0);
    tick();                        expect_pf("pg_idle", 1'b0, 64'h0);
    beat(64'h8000_0118, 64'h2000); expect_pf("pg_re1", 1'b1, 64'h2040);
    tick();                        expect_pf("pg_re2", 1'b1, 64'h2080);
    tick();                        expect_pf("pg_done", 1'b0, 64'h0);

    // Aliasing: same index, different tags, interleaved
    for (int i = 0; i < 4; i++) begin
      beat(64'h8000_0110, 64'h4000 + 64'(i) * 64'h40);
      check_eq("al_a", 64'(pf_v_o | pf_drop_o), 64'h0);
      beat(64'h8000_0150, 64'h6000 + 64'(i) * 64'h40);
      check_eq("al_b", 64'(pf_v_o | pf_drop_o), 64'h0);
    end

    // Flush aborts issue and invalidates the table
    pf_ready_i = 1'b0;
    beat(64'h8000_0114, 64'h7000);
    beat(64'h8000_0114, 64'h7040);
    beat(64'h8000_0114, 64'h7080);
    beat(64'h8000_0114, 64'h70C0); expect_pf("fl_pf1", 1'b1, 64'h7100);
    flush_i = 1'b1;
    tick();
    flush_i = 1'b0;
    expect_pf("fl_abort", 1'b0, 64'h0);
    check_eq("fl_drop", 64'(pf_drop_o), 64'h0);
    pf_ready_i = 1'b1;
    beat(64'h8000_0114, 64'h7100); expect_pf("fl_miss", 1'b0, 64'h0);
    beat(64'h8000_0114, 64'h7140); expect_pf("fl_b2", 1'b0, 64'h0);
    beat(64'h8000_0114, 64'h7180); expect_pf("fl_b3", 1'b0, 64'h0);

    // Asynchronous reset in the middle of issue
    pf_ready_i = 1'b0;
    beat(64'h8000_011C, 64'h9000);
    beat(64'h8000_011C, 64'h9040);
    beat(64'h8000_011C, 64'h9080);
    beat(64'h8000_011C, 64'h90C0); expect_pf("ar_pf1", 1'b1, 64'h9100);
    #3 reset_i = 1'b1;
    #1 expect_pf("ar_async", 1'b0, 64'h0);
    #2 reset_i = 1'b0;
    tick();
    expect_pf("ar_after", 1'b0, 64'h0);
    pf_ready_i = 1'b1;
    beat(64'h8000_011C, 64'h9100); expect_pf("ar_b1", 1'b0, 64'h0);
    beat(64'h8000_011C, 64'h9140); expect_pf("ar_b2", 1'b0, 64'h0);
    beat(64'h8000_011C, 64'h9180); expect_pf("ar_b3", 1'b0, 64'h0);
    beat(64'h8000_011C, 64'h91C0); expect_pf("ar_pf_a", 1'b1, 64'h9200);
    tick();                        expect_pf("ar_pf_b", 1'b1, 64'h9240);
    tick();                        expect_pf("ar_done", 1'b0, 64'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule
